// File: rtl/fft_frame_sched.sv
// fft_frame_sched: round-robin frame scheduler sharing one FFT_IFFT core between two sample sources.
// Latency: gnt -> core_ien one cycle; core_oen -> out_valid one cycle; frames spaced by 1 + GAP_P idle cycles.
// Backpressure: no grant while TAG_DEPTH_P frames are in flight; requests stay pending. Output has no backpressure.
// Optional: define FFT_SCHED_STATS_EN to add per-source grant/completion counters (stat_in0/1, stat_out0/1).

// Small generic synchronous FIFO used for the in-flight source tags.
// Latency: head_dat shows the oldest entry combinationally; a push is visible the cycle after.
// Backpressure: push ignored when full, pop ignored when empty; callers check full/empty.
module fft_sched_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic         iclk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_vld,
  output logic [W-1:0] head_dat,
  output logic         empty,
  output logic         full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == CNT_FULL);
  assign push_ok  = push_vld & ~full;
  assign pop_ok   = pop_vld & ~empty;
  assign head_dat = mem[rd_ptr];

  // Storage, pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

module fft_frame_sched #(
  parameter int TOTAL_STAGE_P = 6,
  parameter int MULT_WIDTH_P  = 18,
  parameter int TAG_DEPTH_P   = 4,
  parameter int GAP_P         = 0
) (
  input  logic                     iclk,
  input  logic                     rst_n,
  input  logic                     req0,
  input  logic                     req1,
  output logic                     gnt0,
  output logic                     gnt1,
  input  logic [MULT_WIDTH_P-1:0]  d0_real,
  input  logic [MULT_WIDTH_P-1:0]  d0_imag,
  input  logic [MULT_WIDTH_P-1:0]  d1_real,
  input  logic [MULT_WIDTH_P-1:0]  d1_imag,
  output logic                     core_ien,
  output logic [TOTAL_STAGE_P-1:0] core_iaddr,
  output logic [MULT_WIDTH_P-1:0]  core_iReal,
  output logic [MULT_WIDTH_P-1:0]  core_iImag,
  input  logic                     core_oen,
  input  logic [TOTAL_STAGE_P-1:0] core_oaddr,
  input  logic [MULT_WIDTH_P-1:0]  core_oReal,
  input  logic [MULT_WIDTH_P-1:0]  core_oImag,
  output logic                     out_valid,
  output logic                     out_src,
  output logic [TOTAL_STAGE_P-1:0] out_addr,
  output logic [MULT_WIDTH_P-1:0]  out_real,
  output logic [MULT_WIDTH_P-1:0]  out_imag,
  output logic                     out_last,
  output logic                     busy,
  output logic                     err_orphan
`ifdef FFT_SCHED_STATS_EN
  ,
  output logic [15:0]              stat_in0,
  output logic [15:0]              stat_in1,
  output logic [15:0]              stat_out0,
  output logic [15:0]              stat_out1
`endif
);
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  localparam logic [TOTAL_STAGE_P-1:0] CNT_LAST = '1;
  localparam logic [TOTAL_STAGE_P-1:0] CNT_ONE  = TOTAL_STAGE_P'(1);
  localparam logic [3:0]               GAP_LAST = (GAP_P > 0) ? 4'(GAP_P - 1) : 4'd0;

  state_t                   state;
  logic [TOTAL_STAGE_P-1:0] cnt;
  logic [3:0]               gap_cnt;
  logic                     rr_last;     // source served most recently
  logic                     pick;        // source that would win in IDLE this cycle
  logic                     grant_fire;  // IDLE -> STREAM this cycle
  logic                     tag_head;
  logic                     tag_empty;
  logic                     tag_full;
  logic                     tag_pop;

  // Single requester wins outright; on a tie the source not served last wins.
  assign pick       = (req0 & req1) ? ~rr_last : req1;
  assign grant_fire = (state == S_IDLE) & (req0 | req1) & ~tag_full;
  // A tag retires only when the last sample of its frame leaves the core.
  assign tag_pop    = core_oen & (core_oaddr == CNT_LAST) & ~tag_empty;
  assign busy       = (state != S_IDLE) | ~tag_empty;

  fft_sched_fifo #(
    .W     (1),
    .DEPTH (TAG_DEPTH_P)
  ) u_tag_fifo (
    .iclk     (iclk),
    .rst_n    (rst_n),
    .push_vld (grant_fire),
    .push_dat (pick),
    .pop_vld  (tag_pop),
    .head_dat (tag_head),
    .empty    (tag_empty),
    .full     (tag_full)
  );

  // Frame FSM: grant a whole frame, stream N samples, optional idle gap.
  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      gap_cnt <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rr_last <= 1'b1;  // makes source 0 win the first tie
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_fire) begin
            state   <= S_STREAM;
            cnt     <= '0;
            gnt0    <= ~pick;
            gnt1    <= pick;
            rr_last <= pick;
          end
        end
        S_STREAM: begin
          if (cnt == CNT_LAST) begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            cnt  <= '0;
            if (GAP_P > 0) begin
              state   <= S_GAP;
              gap_cnt <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) state <= S_IDLE;
          else                     gap_cnt <= gap_cnt + 4'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Input stage: register the granted source's sample with its index; data holds between frames.
  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      core_ien   <= 1'b0;
      core_iaddr <= '0;
      core_iReal <= '0;
      core_iImag <= '0;
    end else begin
      core_ien <= gnt0 | gnt1;
      if (gnt0 | gnt1) begin
        core_iaddr <= cnt;
        core_iReal <= gnt1 ? d1_real : d0_real;
        core_iImag <= gnt1 ? d1_imag : d0_imag;
      end
    end
  end

  // Output stage: tag each core sample with the oldest in-flight source; flag samples with no owner.
  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_src    <= 1'b0;
      out_addr   <= '0;
      out_real   <= '0;
      out_imag   <= '0;
      out_last   <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      out_valid <= core_oen;
      out_last  <= core_oen & (core_oaddr == CNT_LAST);
      if (core_oen) begin
        out_addr <= core_oaddr;
        out_real <= core_oReal;
        out_imag <= core_oImag;
        out_src  <= tag_empty ? 1'b0 : tag_head;
      end
      if (core_oen & tag_empty) err_orphan <= 1'b1;
    end
  end

`ifdef FFT_SCHED_STATS_EN
  // Per-source frame counters: grants issued and frames retired, wrapping at 2^16.
  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      stat_in0  <= '0;
      stat_in1  <= '0;
      stat_out0 <= '0;
      stat_out1 <= '0;
    end else begin
      if (grant_fire) begin
        if (pick) stat_in1 <= stat_in1 + 16'd1;
        else      stat_in0 <= stat_in0 + 16'd1;
      end
      if (tag_pop) begin
        if (tag_head) stat_out1 <= stat_out1 + 16'd1;
        else          stat_out0 <= stat_out0 + 16'd1;
      end
    end
  end
`endif
endmodule

// File: doc/fft_frame_sched.md
Name: fft_frame_sched

Overview:
- Frame-level scheduler sharing one FFT_IFFT core between two sample sources.
- Arbitrates whole frames round-robin and drives the core's ien/iaddr/iReal/iImag with a generated sample index.
- Tags each issued frame with its source ID in an in-flight FIFO, and returns core output samples with that tag.
- Sits between the front-end sample producers and the FFT_IFFT instance.

Parameters:
- TOTAL_STAGE_P, 6: FFT stages; frame length N = 2^TOTAL_STAGE_P. Must match the core.
- MULT_WIDTH_P, 18: real/imag sample width. Must match the core.
- TAG_DEPTH_P, 4: maximum frames in flight inside the core; power of 2, range 2..16.
- GAP_P, 0: extra idle cycles inserted after each issued frame; range 0..15.

Ports:
- iclk in 1: clock, rising edge.
- rst_n in 1: asynchronous active-low reset.
- req0, req1 in 1 each: source requests a frame (level).
- gnt0, gnt1 out 1 each: high for exactly N cycles while that source streams.
- d0_real, d0_imag, d1_real, d1_imag in MULT_WIDTH_P each: source samples, valid every cycle while its gnt is high.
- core_ien out 1: to core ien.
- core_iaddr out TOTAL_STAGE_P: to core iaddr.
- core_iReal, core_iImag out MULT_WIDTH_P: to core iReal/iImag.
- core_oen in 1: from core oen.
- core_oaddr in TOTAL_STAGE_P: from core oaddr.
- core_oReal, core_oImag in MULT_WIDTH_P: from core oReal/oImag.
- out_valid out 1: output sample valid.
- out_src out 1: source ID of the output frame.
- out_addr out TOTAL_STAGE_P: output sample index.
- out_real, out_imag out MULT_WIDTH_P: output sample.
- out_last out 1: high with the sample at index N-1.
- busy out 1: FSM not in IDLE, or tag FIFO not empty.
- err_orphan out 1: sticky; core_oen seen while tag FIFO empty.

Behaviour:
- Reset: all outputs 0; FSM IDLE; cnt=0; tag FIFO empty; round-robin pointer set so source 0 wins the first tie.
- FSM states: IDLE, STREAM, GAP.
- IDLE: if (req0|req1) and tag FIFO not full, select a source and go to STREAM.
  - Only one requester: select it.
  - Both requesting: select the source not served last.
  - On entry to STREAM: gntX=1, cnt=0, push X into the tag FIFO, update the pointer.
- IDLE with FIFO full: wait; requests stay pending and no gnt is given.
- STREAM: gntX=1 and cnt increments each cycle.
  - At cnt==N-1: go to GAP if GAP_P>0, else IDLE.
  - reqX deasserting mid-frame is ignored; the frame always completes all N samples.
- GAP: stay GAP_P cycles, then go to IDLE. gnt is low.
- Minimum spacing between frames: 1 idle cycle (in IDLE) + GAP_P cycles.
- Input pipeline: one register stage. Cycle t (gntX=1, cnt=k, dX) -> cycle t+1: core_ien=1, core_iaddr=k, core_iReal/iImag=dX. core_ien=0 otherwise, with data held at last value.
- Output pipeline: one register stage. On core_oen at cycle t, at t+1:
  - out_valid=1, out_addr=core_oaddr, data copied.
  - out_src = head of tag FIFO.
  - out_last = (core_oaddr==N-1).
- Tag pop: when core_oen & core_oaddr==N-1 & FIFO not empty.
- Push and pop in the same cycle: both occur and the count is unchanged. A push when full is impossible by construction.
- core_oen while FIFO empty: out_valid still asserted, out_src=0, err_orphan set. Cleared only by reset.
- Core latency is not assumed; ordering is by FIFO only. The core outputs frames in issue order.
- Reset mid-frame: immediate abort, gnt drops asynchronously, FIFO cleared.

Optional Feature:
- Macro FFT_SCHED_STATS_EN.
- Defined: adds output ports stat_in0, stat_in1, stat_out0, stat_out1, 16 bits each, reset 0.
  - stat_inX increments at each frame grant to source X.
  - stat_outX increments at each tag pop for source X.
  - Counters wrap at 2^16.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- req0 only, N=64, GAP_P=0, ramp data 0..63 -> gnt0 high 64 cycles; core_iaddr 0..63 one cycle later; next grant after 1 idle cycle.
- req0 and req1 both held high for 4 frames -> grants alternate 0,1,0,1; out_src sequence 0,1,0,1 with out_last on each oaddr=63.
- Core model stalled (no oen) with both requests high, TAG_DEPTH_P=4 -> exactly 4 grants, then none. Release the core -> one new grant per popped frame.
- Drop req1 after 10 cycles of its grant -> gnt1 still high for 64 cycles, 64 core_ien pulses.
- Inject core_oen with FIFO empty -> err_orphan=1, out_valid=1, out_src=0; stays set until rst_n.
- Assert rst_n=0 mid-STREAM at cnt=30 -> gnt, core_ien and busy go 0 immediately. After release, the first tie goes to source 0.
